// File: rtl/tea_pkg.sv
// Shared TEA constants, FSM state type and round function.
// Used by both the encryptor and the decryptor.
package tea_pkg;

  localparam logic [31:0] TEA_DELTA        = 32'h9E3779B9;
  localparam logic [31:0] TEA_DEC_SUM_INIT = 32'hC6EF3720;  // DELTA * 32 mod 2^32
  localparam int          TEA_NUM_ROUNDS   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } tea_state_t;

  // TEA mixing function: ((v<<4)+ka) ^ (v+sum) ^ ((v>>5)+kb), all mod 2^32.
  function automatic logic [31:0] tea_mix(
    input logic [31:0] v,
    input logic [31:0] sum,
    input logic [31:0] ka,
    input logic [31:0] kb
  );
    return ((v << 4) + ka) ^ (v + sum) ^ ((v >> 5) + kb);
  endfunction

endpackage

// File: rtl/tea_dec_round.sv
// One combinational TEA decrypt round: v1 is updated first, then v0 uses the new v1.
module tea_dec_round
  import tea_pkg::*;
(
  input  logic [31:0] v0,
  input  logic [31:0] v1,
  input  logic [31:0] sum,
  input  logic [31:0] k0,
  input  logic [31:0] k1,
  input  logic [31:0] k2,
  input  logic [31:0] k3,
  output logic [31:0] v0_out,
  output logic [31:0] v1_out
);

  assign v1_out = v1 - tea_mix(v0, sum, k2, k3);
  assign v0_out = v0 - tea_mix(v1_out, sum, k0, k1);

endmodule

// File: rtl/tea_decryption.sv
// TEA decryption core: 64-bit ciphertext + 128-bit key -> 64-bit plaintext.
// Optional macro TEA_DEC_UNROLL2_EN chains two rounds per cycle (16-cycle latency);
// results are identical either way.
module tea_decryption
  import tea_pkg::*;
#(
  parameter int NUM_ROUNDS = TEA_NUM_ROUNDS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  input  logic         ctxt_valid,
  input  logic [63:0]  ctxt,
  input  logic [127:0] key,
  output logic [63:0]  ptxt,
  output logic         ptxt_ready
);

`ifdef TEA_DEC_UNROLL2_EN
  localparam int ROUNDS_PER_CYCLE = 2;
`else
  localparam int ROUNDS_PER_CYCLE = 1;
`endif
  localparam int CYCLES = NUM_ROUNDS / ROUNDS_PER_CYCLE;
  localparam int CNT_W  = $clog2(CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYCLES - 1);
  localparam logic [31:0] SUM_STEP = 32'(ROUNDS_PER_CYCLE) * TEA_DELTA;

  tea_state_t       state, state_next;
  logic [31:0]      v0, v1, sum;
  logic [31:0]      k0, k1, k2, k3;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      r_v0, r_v1;
  logic             start;
  logic             last_round;

  // A start is only accepted outside BUSY; BUSY ignores all inputs.
  assign start      = (state != BUSY) && key_valid && ctxt_valid;
  assign last_round = (state == BUSY) && (cnt == LAST_CNT);

`ifdef TEA_DEC_UNROLL2_EN
  logic [31:0] m_v0, m_v1;

  tea_dec_round u_round0 (
    .v0(v0), .v1(v1), .sum(sum),
    .k0(k0), .k1(k1), .k2(k2), .k3(k3),
    .v0_out(m_v0), .v1_out(m_v1)
  );

  // Second round of the pair sees the sum one DELTA lower.
  tea_dec_round u_round1 (
    .v0(m_v0), .v1(m_v1), .sum(sum - TEA_DELTA),
    .k0(k0), .k1(k1), .k2(k2), .k3(k3),
    .v0_out(r_v0), .v1_out(r_v1)
  );
`else
  tea_dec_round u_round0 (
    .v0(v0), .v1(v1), .sum(sum),
    .k0(k0), .k1(k1), .k2(k2), .k3(k3),
    .v0_out(r_v0), .v1_out(r_v1)
  );
`endif

  // State register with synchronous reset.
  // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would create ordering races.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start)      state_next = BUSY;
      BUSY:       if (last_round) state_next = DONE;
      default:                    state_next = IDLE;
    endcase
  end

  // Datapath: load on start, iterate rounds while BUSY, publish result on the last round.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0         <= '0;
      v1         <= '0;
      k0         <= '0;
      k1         <= '0;
      k2         <= '0;
      k3         <= '0;
      sum        <= '0;
      cnt        <= '0;
      ptxt       <= '0;
      ptxt_ready <= 1'b0;
    end else if (start) begin
      v0         <= ctxt[63:32];
      v1         <= ctxt[31:0];
      k0         <= key[127:96];
      k1         <= key[95:64];
      k2         <= key[63:32];
      k3         <= key[31:0];
      sum        <= TEA_DEC_SUM_INIT;
      cnt        <= '0;
      ptxt_ready <= 1'b0;   // ptxt keeps its old value until the new result lands
    end else if (state == BUSY) begin
      v0  <= r_v0;
      v1  <= r_v1;
      sum <= sum - SUM_STEP;
      cnt <= cnt + CNT_W'(1);
      if (last_round) begin
        ptxt       <= {r_v0, r_v1};
        ptxt_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tea_decryption.sv
// Self-checking bench for tea_decryption against a loop-based TEA reference model.
module tb_tea_decryption;

`ifdef TEA_DEC_UNROLL2_EN
  localparam int LAT = 16;
`else
  localparam int LAT = 32;
`endif
  localparam logic [31:0] DELTA = 32'h9E3779B9;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         key_valid = 1'b0;
  logic         ctxt_valid = 1'b0;
  logic [63:0]  ctxt = '0;
  logic [127:0] key = '0;
  logic [63:0]  ptxt;
  logic         ptxt_ready;

  int total = 0;
  int bad = 0;

  tea_decryption dut (
    .clk(clk), .rst_n(rst_n),
    .key_valid(key_valid), .ctxt_valid(ctxt_valid),
    .ctxt(ctxt), .key(key),
    .ptxt(ptxt), .ptxt_ready(ptxt_ready)
  );

  always #5 clk = ~clk;

  // Reference: textbook TEA encryption, sum counts up from 0.
  function automatic logic [63:0] ref_encrypt(input logic [63:0] pt, input logic [127:0] k);
    logic [31:0] a, b, s;
    logic [31:0] kw [4];
    a = pt[63:32]; b = pt[31:0]; s = 0;
    for (int i = 0; i < 4; i++) kw[i] = k[127-32*i -: 32];
    for (int r = 0; r < 32; r++) begin
      s = s + DELTA;
      a = a + (((b << 4) + kw[0]) ^ (b + s) ^ ((b >> 5) + kw[1]));
      b = b + (((a << 4) + kw[2]) ^ (a + s) ^ ((a >> 5) + kw[3]));
    end
    return {a, b};
  endfunction

  // Reference: textbook TEA decryption, sum counts down from 32*DELTA.
  function automatic logic [63:0] ref_decrypt(input logic [63:0] ct, input logic [127:0] k);
    logic [31:0] a, b, s;
    logic [31:0] kw [4];
    a = ct[63:32]; b = ct[31:0]; s = DELTA * 32;
    for (int i = 0; i < 4; i++) kw[i] = k[127-32*i -: 32];
    for (int r = 0; r < 32; r++) begin
      b = b - (((a << 4) + kw[2]) ^ (a + s) ^ ((a >> 5) + kw[3]));
      a = a - (((b << 4) + kw[0]) ^ (b + s) ^ ((b >> 5) + kw[1]));
      s = s - DELTA;
    end
    return {a, b};
  endfunction

  // Present a start for exactly one edge; returns #1 after the accepting edge.
  task automatic do_start(input logic [127:0] k, input logic [63:0] c);
    key = k; ctxt = c; key_valid = 1'b1; ctxt_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0; ctxt_valid = 1'b0;
  endtask

  // Count edges until ptxt_ready is seen high; bounded.
  task automatic wait_ready(output int cycles);
    cycles = 0;
    for (int i = 0; i < LAT + 10; i++) begin
      @(posedge clk); #1;
      cycles++;
      if (ptxt_ready) return;
    end
    total++; bad++;
    $display("FAIL wait_ready: ptxt_ready never rose within %0d cycles", LAT + 10);
    cycles = -1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_idle(input string name);
    total++;
    if (ptxt !== 64'h0 || ptxt_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s: ptxt=%h ready=%b, want ptxt=0 ready=0", name, ptxt, ptxt_ready);
    end
  endtask

  task automatic check_result(input string name, input logic [63:0] want, input int cycles, input int want_cycles);
    total++;
    if (ptxt !== want) begin
      bad++;
      $display("FAIL %s ptxt: got %h want %h", name, ptxt, want);
    end
    total++;
    if (cycles !== want_cycles) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", name, cycles, want_cycles);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    check_idle("reset");
  endtask

  task automatic test_known_vector();
    int c;
    do_start(128'h0, 64'h41EA3A0A94BAA940);
    wait_ready(c);
    check_result("known_vector", 64'h0, c, LAT);
  endtask

  task automatic test_random_roundtrip();
    logic [127:0] k;
    logic [63:0]  pt, ct;
    int c;
    for (int n = 0; n < 8; n++) begin
      k  = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom};
      ct = ref_encrypt(pt, k);
      total++;
      if (ref_decrypt(ct, k) !== pt) begin
        bad++;
        $display("FAIL model_roundtrip: got %h want %h", ref_decrypt(ct, k), pt);
      end
      do_start(k, ct);
      wait_ready(c);
      check_result("random_roundtrip", pt, c, LAT);
    end
  endtask

  task automatic test_single_valid();
    apply_reset();
    key = {$urandom, $urandom, $urandom, $urandom};
    ctxt = {$urandom, $urandom};
    key_valid = 1'b1; ctxt_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 check_idle("key_valid_only");
    key_valid = 1'b0; ctxt_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 check_idle("ctxt_valid_only");
    ctxt_valid = 1'b0;
    repeat (LAT + 3) @(posedge clk);
    #1 check_idle("single_valid_no_result");
  endtask

  task automatic test_reset_mid_busy();
    int c;
    do_start(128'h0123456789ABCDEF_FEDCBA9876543210, 64'hDEADBEEF_CAFEF00D);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_idle("reset_mid_busy");
    repeat (LAT + 3) @(posedge clk);
    #1 check_idle("reset_mid_busy_stays_idle");
    do_start(128'h0, 64'h41EA3A0A94BAA940);
    wait_ready(c);
    check_result("after_reset_restart", 64'h0, c, LAT);
  endtask

  task automatic test_busy_ignore();
    logic [127:0] ka;
    logic [63:0]  pa;
    int c;
    ka = {$urandom, $urandom, $urandom, $urandom};
    pa = {$urandom, $urandom};
    do_start(ka, ref_encrypt(pa, ka));
    key = ~ka; ctxt = {$urandom, $urandom};
    key_valid = 1'b1; ctxt_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1 key_valid = 1'b0; ctxt_valid = 1'b0;
    wait_ready(c);
    check_result("busy_ignore", pa, c, LAT - 10);
  endtask

  task automatic test_back_to_back();
    logic [127:0] k1, k2;
    logic [63:0]  p1, p2;
    int c;
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    p1 = {$urandom, $urandom};
    p2 = {$urandom, $urandom};
    do_start(k1, ref_encrypt(p1, k1));
    wait_ready(c);
    check_result("b2b_first", p1, c, LAT);
    // New start on the first ready cycle.
    do_start(k2, ref_encrypt(p2, k2));
    total++;
    if (ptxt_ready !== 1'b0 || ptxt !== p1) begin
      bad++;
      $display("FAIL b2b_hold: ready=%b ptxt=%h, want ready=0 ptxt=%h", ptxt_ready, ptxt, p1);
    end
    wait_ready(c);
    check_result("b2b_second", p2, c, LAT);
    // DONE holds its result while no start is offered.
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (ptxt_ready !== 1'b1 || ptxt !== p2) begin
      bad++;
      $display("FAIL done_hold: ready=%b ptxt=%h, want ready=1 ptxt=%h", ptxt_ready, ptxt, p2);
    end
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_random_roundtrip();
    test_single_valid();
    test_reset_mid_busy();
    test_busy_ignore();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
